// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB slave with byte-lane strobes, fixed wait states and a flop-based word memory.
// Define APB_SLVERR_EN to flag out-of-range transfers on PSLVERR; otherwise PSLVERR is tied 0.
module apb_mem_slave #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W/8-1:0]   PSTRB,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int              STRB_W    = DATA_W / 8;
    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DEPTH_V   = (ADDR_W + 1)'(DEPTH);

    // ST_WAIT: access phase with PREADY low; ST_READY: the single PREADY-high cycle.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_e;

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic                write_q;
    logic                oor_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic                pready_q;
    logic [DATA_W-1:0]   prdata_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                setup_req;
    logic                access_req;
    logic                bus_oor;
    logic                ready_rise;
    logic                rise_write;
    logic                rise_oor;
    logic [IDX_W-1:0]    rise_idx;
    logic                commit;
    logic [DATA_W-1:0]   rdata_d;

    // The edge that raises PREADY is either the capture edge (no wait states) or the
    // last wait edge; the rise_* muxes pick live bus fields or the captured ones.
    always_comb begin
        setup_req  = PSEL && !PENABLE;
        access_req = PSEL && PENABLE;
        bus_oor    = $isunknown(PADDR) || ({1'b0, PADDR} >= DEPTH_V);
        ready_rise = setup_req ? (WAIT_INIT == 4'd0)
                               : ((state_q == ST_WAIT) && access_req && (cnt_q == 4'd1));
        rise_write = setup_req ? PWRITE : write_q;
        rise_oor   = setup_req ? bus_oor : oor_q;
        rise_idx   = setup_req ? PADDR[IDX_W-1:0] : idx_q;
        commit     = (state_q == ST_READY) && access_req && write_q && !oor_q;
        rdata_d    = rise_oor ? '0 : mem_q[rise_idx];
    end

    // A low PSEL or PENABLE before completion abandons the transfer; PSEL high with
    // PENABLE low always starts a fresh one, even from inside an access phase.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            oor_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            pready_q <= 1'b0;
            prdata_q <= '0;
        end else begin
            pready_q <= ready_rise;
            if (ready_rise && !rise_write) begin
                prdata_q <= rdata_d;
            end
            if (setup_req) begin
                write_q <= PWRITE;
                oor_q   <= bus_oor;
                idx_q   <= PADDR[IDX_W-1:0];
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
                cnt_q   <= WAIT_INIT;
                state_q <= ready_rise ? ST_READY : ST_WAIT;
            end else begin
                case (state_q)
                    ST_WAIT: begin
                        if (!access_req) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= 4'd0;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                            if (cnt_q == 4'd1) begin
                                state_q <= ST_READY;
                            end
                        end
                    end
                    ST_READY: state_q <= ST_IDLE;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: the memory is reset like any other state because a cleared memory after
    // PRESET is part of the contract; this makes it flops, never an inferred RAM.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else if (commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

`ifdef APB_SLVERR_EN
    logic pslverr_q;

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= ready_rise && rise_oor;
        end
    end

    assign PSLVERR = pslverr_q;
`else
    assign PSLVERR = 1'b0;
`endif

    assign PREADY = pready_q;
    assign PRDATA = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: one zero-wait and one three-wait instance driven by directed APB
// transfers; expected completions are queued at drive time and popped at PREADY.
module tb_apb_mem_slave;

    localparam int WAIT_A = 0;
    localparam int WAIT_B = 3;

`ifdef APB_SLVERR_EN
    localparam logic ERR_OOR = 1'b1;
`else
    localparam logic ERR_OOR = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic        is_read;
        logic [31:0] rdata;
        logic        err;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [7:0]  paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];

    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b;
    logic        pslverr_a, pslverr_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(WAIT_A)) u_dut_a (
        .PCLK(clk), .PRESET(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
        .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
    );

    apb_mem_slave #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(WAIT_B)) u_dut_b (
        .PCLK(clk), .PRESET(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
        .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
    );

    function automatic logic rdy(input int d);
        return (d == 0) ? pready_a : pready_b;
    endfunction

    function automatic logic [31:0] rd(input int d);
        return (d == 0) ? prdata_a : prdata_b;
    endfunction

    function automatic logic err(input int d);
        return (d == 0) ? pslverr_a : pslverr_b;
    endfunction

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed 0x%08h expected 0x%08h", tag, what, obs, exp);
        end
    endtask

    // Starts at #1 after an edge, ends at #1 after the completion edge with the bus idle,
    // so two calls in a row form a back-to-back pair with no idle cycle.
    task automatic apb_xfer(input int d, input logic wr, input logic [7:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input string tag);
        exp_t e;
        exp_t got;
        int   cyc;
        e.tag     = tag;
        e.is_read = !wr;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.cycles  = ((d == 0) ? WAIT_A : WAIT_B) + 2;
        sb_q.push_back(e);

        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        pstrb[d]   = strb;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        cyc = 2;
        while (!rdy(d) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end

        got = sb_q.pop_front();
        check(got.tag, "pready", 32'(rdy(d)), 32'd1);
        check(got.tag, "cycles", cyc, got.cycles);
        if (got.is_read) begin
            check(got.tag, "prdata", rd(d), got.rdata);
        end
        check(got.tag, "pslverr", 32'(err(d)), 32'(got.err));

        @(posedge clk); #1;
        check(got.tag, "pready_drop", 32'(rdy(d)), 32'd0);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset", "pready_a",  32'(pready_a),  32'd0);
        check("reset", "prdata_a",  prdata_a,       32'd0);
        check("reset", "pslverr_a", 32'(pslverr_a), 32'd0);
        check("reset", "pready_b",  32'(pready_b),  32'd0);
        check("reset", "prdata_b",  prdata_b,       32'd0);
        check("reset", "pslverr_b", 32'(pslverr_b), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait instance: full write/read, strobe merge, empty strobe.
        apb_xfer(0, 1'b1, 8'h05, 32'h0000ABCD, 4'b1111, 32'h0, 1'b0, "wr05");
        apb_xfer(0, 1'b0, 8'h05, 32'h0,        4'b0000, 32'h0000ABCD, 1'b0, "rd05");
        apb_xfer(0, 1'b1, 8'h0A, 32'h000AAAAA, 4'b1111, 32'h0, 1'b0, "wr0A_pre");
        apb_xfer(0, 1'b1, 8'h0A, 32'h33003300, 4'b1010, 32'h0, 1'b0, "wr0A_strb");
        apb_xfer(0, 1'b0, 8'h0A, 32'h0,        4'b0000, 32'h330A33AA, 1'b0, "rd0A_merge");
        apb_xfer(0, 1'b1, 8'h05, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, "wr05_nostrb");
        apb_xfer(0, 1'b0, 8'h05, 32'h0,        4'b0000, 32'h0000ABCD, 1'b0, "rd05_nostrb");

        // Out-of-range: 0x1F aliases word 0x0F in the low index bits, which must stay 0.
        apb_xfer(0, 1'b1, 8'h1F, 32'hCAFEF00D, 4'b1111, 32'h0, ERR_OOR, "wr1F_oor");
        apb_xfer(0, 1'b0, 8'h1F, 32'h0,        4'b0000, 32'h0, ERR_OOR, "rd1F_oor");
        apb_xfer(0, 1'b0, 8'h0A, 32'h0,        4'b0000, 32'h330A33AA, 1'b0, "rd0A_again");
        apb_xfer(0, 1'b0, 8'h0F, 32'h0,        4'b0000, 32'h0, 1'b0, "rd0F_alias");
        apb_xfer(0, 1'b0, 8'h05, 32'h0,        4'b0000, 32'h0000ABCD, 1'b0, "rd05_pre10");
        apb_xfer(0, 1'b0, 8'h10, 32'h0,        4'b0000, 32'h0, ERR_OOR, "rd10_edge");

        // Back-to-back on the zero-wait instance.
        apb_xfer(0, 1'b1, 8'h03, 32'h12345678, 4'b1111, 32'h0, 1'b0, "b2b_wr03_a");
        apb_xfer(0, 1'b0, 8'h03, 32'h0,        4'b0000, 32'h12345678, 1'b0, "b2b_rd03_a");

        // Three-wait instance: a read takes five cycles.
        apb_xfer(1, 1'b0, 8'h0F, 32'h0, 4'b0000, 32'h0, 1'b0, "rd0F_wait");

        // Abort: PENABLE drops mid-wait on a write to 0x03, then PSEL drops.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'h03; pwdata[1] = 32'hBAD0BAD0; pstrb[1] = 4'b1111;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        check("abort", "pready_wait", 32'(pready_b), 32'd0);
        penable[1] = 1'b0;
        @(posedge clk); #1;
        check("abort", "pready_drop", 32'(pready_b), 32'd0);
        psel[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort", "pready_idle", 32'(pready_b), 32'd0);
        end
        apb_xfer(1, 1'b0, 8'h03, 32'h0, 4'b0000, 32'h0, 1'b0, "rd03_after_abort");

        apb_xfer(1, 1'b1, 8'h03, 32'h12345678, 4'b1111, 32'h0, 1'b0, "b2b_wr03_b");
        apb_xfer(1, 1'b0, 8'h03, 32'h0,        4'b0000, 32'h12345678, 1'b0, "b2b_rd03_b");
        apb_xfer(1, 1'b1, 8'h07, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, "wr07");
        apb_xfer(1, 1'b0, 8'h07, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0, "rd07");

        // Reset during the wait phase of a write to 0x07.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'h07; pwdata[1] = 32'h11111111; pstrb[1] = 4'b1111;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset", "pready",  32'(pready_b),  32'd0);
        check("midreset", "prdata",  prdata_b,       32'd0);
        check("midreset", "pslverr", 32'(pslverr_b), 32'd0);
        rst_n = 1'b1;
        psel[1] = 1'b0;
        penable[1] = 1'b0;
        @(posedge clk); #1;
        apb_xfer(1, 1'b0, 8'h07, 32'h0, 4'b0000, 32'h0, 1'b0, "rd07_after_reset");
        apb_xfer(0, 1'b0, 8'h05, 32'h0, 4'b0000, 32'h0, 1'b0, "rd05_after_reset");

        check("scoreboard", "empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB slave with byte-lane write strobes, configurable wait states and error response, backed by a flop-based word memory. It is the next-generation peripheral-side endpoint on the team's APB bus. It replaces the fixed 8-bit-address / 32-bit-data slave with a full PSEL/PENABLE/PREADY handshake.

## Interface
- ADDR_W, 8: width of PADDR; PADDR is a word index, not a byte address.
- DATA_W, 32: data width; must be a multiple of 8. Strobe width is DATA_W/8.
- DEPTH, 16: number of words implemented; 1 ≤ DEPTH ≤ 2^ADDR_W.
- WAIT_CYCLES, 0: PREADY-low cycles inserted in every ACCESS phase; range 0..15.
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  word index.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  byte-lane write enables; ignored on reads.
- PRDATA  out  DATA_W  read data; valid only while PREADY=1 on a read.
- PREADY  out  1  transfer-complete, registered.
- PSLVERR  out  1  error response; valid only while PREADY=1.

## Operation
- FSM states:
  - IDLE -> SETUP when PSEL=1 and PENABLE=0 are sampled. PWRITE, PADDR, PWDATA and PSTRB are captured on that edge.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> IDLE, or -> SETUP if a new PSEL=1 / PENABLE=0 is present, on the edge where PREADY=1 is sampled.
- Wait counter:
  - Loaded with WAIT_CYCLES on the SETUP-capture edge.
  - Decrements on each ACCESS edge while non-zero.
  - PREADY rises on the edge where the counter is 0 and the state is SETUP or ACCESS.
- Write commit:
  - Occurs on the completion edge (PREADY=1 sampled).
  - Byte lane i of mem[addr] is updated iff PSTRB[i]=1; other lanes are unchanged.
  - PSTRB=0 leaves the memory unchanged and the transfer still completes.
- Read: PRDATA is loaded from mem[addr] on the edge that raises PREADY. It holds its value until the next read load or reset.
- Abort: if PSEL or PENABLE is sampled 0 while in ACCESS before completion, the FSM returns to IDLE with no write and PREADY=0.
- Out-of-range: a transfer is out-of-range when addr ≥ DEPTH or PADDR contains X/Z at capture. Behaviour is set by the Configuration macro.
- Reset:
  - PREADY=0, PSLVERR=0, PRDATA=0, state IDLE, counter 0.
  - All memory words are cleared to 0.
  - Reset asserted mid-transfer discards the transfer.

## Timing
- Zero wait states (WAIT_CYCLES=0):
  - Edge 0 samples SETUP.
  - PREADY=1 throughout the first ACCESS cycle.
  - Edge 1 completes the transfer.
  - Total 2 cycles per transfer.
- N wait states: PREADY=1 during the (N+1)th ACCESS cycle. Transfer is N+2 cycles.
- PREADY is high for exactly one cycle per transfer. It is cleared on the completion edge unless a back-to-back SETUP reloads the pipeline; even then it drops for at least the SETUP cycle.
- A read immediately after a write to the same address returns the new data: the write commits on the completion edge, before the next SETUP capture.

## Configuration
- APB_SLVERR_EN defined:
  - An out-of-range transfer completes normally with PSLVERR=1 in its PREADY cycle.
  - A write is dropped and a read returns PRDATA=0.
  - PSLVERR=0 for all in-range transfers.
- APB_SLVERR_EN undefined:
  - PSLVERR is tied 0.
  - Out-of-range writes are silently dropped and reads return 0.
  - PREADY timing is identical to the defined case.

## Test plan
- Reset then full write: write addr 0x05, PWDATA=0x0000ABCD, PSTRB=4'b1111, then read addr 0x05 -> PRDATA=0x0000ABCD, PSLVERR=0, each transfer 2 cycles.
- Strobe merge: preload 0x0A=0x000AAAAA, write 0x33003300 with PSTRB=4'b1010, then read -> 0x330A33AA.
- Wait states: with WAIT_CYCLES=3, read addr 0x0F -> PREADY low for 3 ACCESS cycles, high on the 4th, transfer 5 cycles, PRDATA valid only in the PREADY cycle.
- Out-of-range: with APB_SLVERR_EN defined, write addr 0x1F (DEPTH=16) -> PSLVERR=1 and memory unchanged; a read of 0x1F -> PRDATA=0, PSLVERR=1. Without the macro -> PSLVERR=0 and the same data results.
- Abort and back-to-back:
  - Drop PENABLE mid-wait on a write to 0x03 -> mem[0x03] stays 0.
  - Back-to-back write 0x03=0x12345678 then read 0x03 with no idle cycle -> 0x12345678.
- Reset mid-operation: assert PRESET=0 during ACCESS of a write to 0x07 -> next cycle PREADY=0 and PRDATA=0; a subsequent read of 0x07 -> 0.
